// File: rtl/snn_pkg.sv
// Shared types for the spike scheduler slice.
// FSM state encoding and default neuron count.
package snn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int N_DEF = 8;

endpackage

// File: rtl/snn_rr_pick.sv
// Combinational round-robin picker over P_N requesters.
// Search starts just above ptr and wraps from P_N to 1.
module snn_rr_pick
  import snn_pkg::*;
#(
  parameter int P_N = N_DEF,
  parameter int PW  = $clog2(P_N + 1)
) (
  input  logic [P_N:1]  req,
  input  logic [PW-1:0] ptr,
  output logic [P_N:1]  grant,
  output logic          any
);

  logic [2*P_N-1:0] dbl;
  logic [2*P_N-1:0] msk;
  logic [2*P_N-1:0] hit;
  logic             found;

  // Bit j of the doubled vector is neuron (j mod P_N)+1;
  // masking below ptr leaves ptr+1..P_N then the wrapped copy.
  always_comb begin
    dbl   = {req, req};
    msk   = '0;
    grant = '0;
    found = 1'b0;
    for (int j = 0; j < 2*P_N; j++) begin
      msk[j] = (j >= int'(ptr));
    end
    hit = dbl & msk;
    for (int j = 0; j < 2*P_N; j++) begin
      if (!found && hit[j]) begin
        found                = 1'b1;
        grant[(j % P_N) + 1] = 1'b1;
      end
    end
    any = |req;
  end

endmodule

// File: rtl/spike_scheduler.sv
// Serialises latched neuron spike events onto a one-hot index bus,
// one grant at a time, round-robin, with a hold and quiet gap.
module spike_scheduler
  import snn_pkg::*;
#(
  parameter int P_N    = N_DEF,
  parameter int P_HOLD = 1,
  parameter int P_GAP  = 3
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [P_N:1] i_req,
  input  logic         i_en,
  input  logic         i_flush,
  output logic [P_N:1] o_index,
  output logic         o_valid,
  output logic         o_busy,
  output logic [P_N:1] o_pending,
  output logic         o_drop
);

  localparam int PW = $clog2(P_N + 1);
  localparam int MX = (P_HOLD > P_GAP) ? P_HOLD : P_GAP;
  localparam int CW = $clog2(MX + 1);
  localparam logic [CW-1:0] HOLD_LD = CW'(P_HOLD - 1);
  localparam logic [CW-1:0] GAP_LD  =
    (P_GAP > 0) ? CW'(P_GAP - 1) : '0;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [PW-1:0] ptr;
  logic [PW-1:0] pick_idx;
  logic [P_N:1]  req_d;
  logic [P_N:1]  rise;
  logic [P_N:1]  pick;
  logic [P_N:1]  clr;
  logic [P_N:1]  pend_nxt;
  logic          drop_nxt;
  logic          any;
  logic          take;

  snn_rr_pick #(
    .P_N (P_N),
    .PW  (PW)
  ) u_pick (
    .req   (o_pending),
    .ptr   (ptr),
    .grant (pick),
    .any   (any)
  );

  assign rise   = i_req & ~req_d;
  assign take   = (state == ST_IDLE) & i_en & any & ~i_flush;
  assign clr    = take ? pick : '0;
  assign o_busy = (state != ST_IDLE);

  // A new edge re-arms a bit even if it is granted this cycle.
  always_comb begin
    pend_nxt = '0;
    drop_nxt = 1'b0;
    if (!i_flush) begin
      pend_nxt = (o_pending & ~clr) | rise;
      drop_nxt = |(rise & o_pending & ~clr);
    end
  end

  always_comb begin
    pick_idx = '0;
    for (int k = 1; k <= P_N; k++) begin
      if (pick[k]) pick_idx = PW'(k);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      ptr       <= PW'(P_N);
      req_d     <= '0;
      o_pending <= '0;
      o_drop    <= 1'b0;
      o_index   <= '0;
      o_valid   <= 1'b0;
    end else begin
      req_d     <= i_req;
      o_pending <= pend_nxt;
      o_drop    <= drop_nxt;
      if (i_flush) begin
        state   <= ST_IDLE;
        cnt     <= '0;
        o_index <= '0;
        o_valid <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (take) begin
              o_index <= pick;
              o_valid <= 1'b1;
              ptr     <= pick_idx;
              cnt     <= HOLD_LD;
              state   <= ST_ISSUE;
            end
          end
          ST_ISSUE: begin
            if (cnt == '0) begin
              o_index <= '0;
              o_valid <= 1'b0;
              if (P_GAP > 0) begin
                state <= ST_GAP;
                cnt   <= GAP_LD;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          ST_GAP: begin
            if (cnt == '0) state <= ST_IDLE;
            else           cnt   <= cnt - 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spike_scheduler.sv
// Directed bench for spike_scheduler: single event, burst order,
// fairness, overflow drop, flush/enable and async reset mid-gap.
module tb_spike_scheduler;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [8:1] i_req;
  logic       i_en;
  logic       i_flush;
  logic [8:1] o_index;
  logic       o_valid;
  logic       o_busy;
  logic [8:1] o_pending;
  logic       o_drop;

  int n_chk = 0;
  int n_ok  = 0;
  int cyc   = 0;
  int drop_cnt = 0;
  int inv_bad  = 0;
  logic prev_v = 1'b0;
  logic [7:0] gq[$];
  int         gc[$];
  int b;
  int bd;
  logic [7:0] e3 [4];

  spike_scheduler #(
    .P_N    (8),
    .P_HOLD (1),
    .P_GAP  (3)
  ) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_req     (i_req),
    .i_en      (i_en),
    .i_flush   (i_flush),
    .o_index   (o_index),
    .o_valid   (o_valid),
    .o_busy    (o_busy),
    .o_pending (o_pending),
    .o_drop    (o_drop)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (o_valid && !prev_v) begin
      gq.push_back(o_index);
      gc.push_back(cyc);
    end
    prev_v <= o_valid;
    if (o_drop) drop_cnt <= drop_cnt + 1;
    if ((o_valid !== (o_index != 8'h00)) ||
        ($countones(o_index) > 1))
      inv_bad <= inv_bad + 1;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic wait_n(input int n, input int budget);
    for (int i = 0; i < budget && gq.size() < n; i++)
      @(negedge i_clk);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && (o_busy || o_pending != 0); i++)
      @(negedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    i_req   = '0;
    i_en    = 1'b1;
    i_flush = 1'b0;
    i_rst   = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    i_rst = 1'b1; i_req = '0; i_en = 1'b1; i_flush = 1'b0;
    nclk(2);
    check("rst_valid", o_valid, 0);
    check("rst_index", o_index, 0);
    check("rst_busy", o_busy, 0);
    check("rst_pend", o_pending, 0);
    check("rst_drop", o_drop, 0);
    i_rst = 1'b0;
    nclk(1);

    // T1 single event on bit 3
    b = gq.size();
    i_req = 8'h04;
    nclk(1);
    check("t1_pend", o_pending, 8'h04);
    check("t1_nov", o_valid, 0);
    nclk(1);
    check("t1_valid", o_valid, 1);
    check("t1_index", o_index, 8'h04);
    check("t1_pclr", o_pending, 0);
    check("t1_busy0", o_busy, 1);
    nclk(1);
    check("t1_vdone", o_valid, 0);
    check("t1_gap1", o_busy, 1);
    nclk(1);
    check("t1_gap2", o_busy, 1);
    nclk(1);
    check("t1_gap3", o_busy, 1);
    nclk(1);
    check("t1_idle", o_busy, 0);
    check("t1_ngr", gq.size() - b, 1);
    i_req = '0;

    // T2 burst of all eight
    do_reset();
    b  = gq.size();
    bd = drop_cnt;
    i_req = 8'hFF;
    wait_n(b + 8, 60);
    check("t2_cnt", gq.size() - b, 8);
    for (int i = 0; i < 8 && b + i < gq.size(); i++) begin
      check("t2_idx", gq[b+i], 32'(1) << i);
      if (i > 0)
        check("t2_gap", gc[b+i] - gc[b+i-1], 5);
    end
    wait_idle();
    check("t2_drop", drop_cnt - bd, 0);
    check("t2_pend", o_pending, 0);
    i_req = '0;
    nclk(1);

    // T3 fairness after grant of 5 with {2,7} pending
    do_reset();
    b = gq.size();
    i_req = 8'h10;
    nclk(1);
    i_req = 8'h52;
    nclk(1);
    check("t3_g5", o_index, 8'h10);
    check("t3_pend", o_pending, 8'h42);
    i_req = 8'h42;
    nclk(2);
    i_req = 8'h52;
    wait_n(b + 4, 40);
    e3 = '{8'h10, 8'h40, 8'h02, 8'h10};
    check("t3_cnt", gq.size() - b, 4);
    for (int i = 0; i < 4 && b + i < gq.size(); i++)
      check("t3_ord", gq[b+i], e3[i]);
    i_req = '0;
    wait_idle();

    // T4 overflow on bit 6 while grants are disabled
    b  = gq.size();
    bd = drop_cnt;
    i_en = 1'b0;
    i_req = 8'h20;
    nclk(1);
    check("t4_pend", o_pending, 8'h20);
    i_req = '0;
    nclk(1);
    i_req = 8'h20;
    nclk(1);
    check("t4_drop", o_drop, 1);
    check("t4_hold", o_pending, 8'h20);
    check("t4_nov", o_valid, 0);
    nclk(1);
    check("t4_drop0", o_drop, 0);
    i_en = 1'b1;
    wait_n(b + 1, 20);
    nclk(10);
    check("t4_once", gq.size() - b, 1);
    if (gq.size() > b) check("t4_idx", gq[b], 8'h20);
    check("t4_ndrop", drop_cnt - bd, 1);
    i_req = '0;
    wait_idle();

    // T5a flush during issue
    b = gq.size();
    i_req = 8'h88;
    nclk(1);
    check("t5_pend", o_pending, 8'h88);
    nclk(1);
    check("t5_g8", o_index, 8'h80);
    check("t5_p4", o_pending, 8'h08);
    i_flush = 1'b1;
    nclk(1);
    i_flush = 1'b0;
    check("t5_fv", o_valid, 0);
    check("t5_fi", o_index, 0);
    check("t5_fp", o_pending, 0);
    check("t5_fb", o_busy, 0);
    nclk(8);
    check("t5_nogr", gq.size() - b, 1);
    i_req = '0;
    nclk(1);

    // T5b enable gating with 8'h81 pending
    i_en = 1'b0;
    i_req = 8'h81;
    nclk(4);
    check("t5_hp", o_pending, 8'h81);
    check("t5_hv", o_valid, 0);
    check("t5_hb", o_busy, 0);
    b = gq.size();
    i_en = 1'b1;
    nclk(1);
    check("t5_ev", o_valid, 1);
    check("t5_g1", o_index, 8'h01);
    wait_n(b + 2, 20);
    check("t5_n2", gq.size() - b, 2);
    if (gq.size() > b + 1) check("t5_g8b", gq[b+1], 8'h80);
    i_req = '0;
    wait_idle();

    // T6 async reset in gap, pointer restarts at bit 1
    i_req = 8'h12;
    nclk(2);
    check("t6_g2", o_index, 8'h02);
    nclk(1);
    check("t6_gap", o_busy, 1);
    @(posedge i_clk);
    #2;
    i_rst = 1'b1;
    i_req = '0;
    #1;
    check("t6_rv", o_valid, 0);
    check("t6_ri", o_index, 0);
    check("t6_rb", o_busy, 0);
    check("t6_rp", o_pending, 0);
    check("t6_rd", o_drop, 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    nclk(1);
    b = gq.size();
    i_req = 8'h05;
    nclk(2);
    check("t6_v", o_valid, 1);
    check("t6_g1", o_index, 8'h01);
    wait_n(b + 2, 20);
    check("t6_n2", gq.size() - b, 2);
    if (gq.size() > b + 1) check("t6_g3", gq[b+1], 8'h04);
    i_req = '0;
    wait_idle();

    check("onehot_inv", inv_bad, 0);
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
